// File: rtl/uart_rx_deframer_if.sv
// rtl/uart_rx_deframer_if.sv - valid/ready byte handshake between the UART receiver and its consumer
interface uart_rx_deframer_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_deframer.sv
// rtl/uart_rx_deframer.sv - 8N1 UART receiver with mid-bit sampling, 1-entry holding register,
// framing-error and overrun pulses
module uart_rx_deframer #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8
) (
  input  logic               CLK100MHZ,
  input  logic               reset_n,
  input  logic               i_rxd,
  uart_rx_deframer_if.master rx_if,
  output logic               o_frame_err,
  output logic               o_overrun,
  output logic               o_busy
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam int BW           = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0]        HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]        BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]        DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [DATA_BITS-1:0] MSB_ONE   = DATA_BITS'(1) << (DATA_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic [2:0]           r_state;
  logic [CW-1:0]        r_clk_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic                 r_sync1;
  logic                 r_rxs;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_overrun;

  logic                 w_take;

  assign w_take = r_valid & rx_if.rx_ready;

  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_clk_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_sync1     <= 1'b1;
      r_rxs       <= 1'b1;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_sync1     <= i_rxd;
      r_rxs       <= r_sync1;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;

      // A delivery further down overrides this drop when both land on one edge.
      if (w_take) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (!r_rxs) begin
            r_state   <= S_START;
            r_clk_cnt <= '0;
          end
        end
        S_START: begin
          if (r_clk_cnt == HALF_LAST) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_state   <= r_rxs ? S_IDLE : S_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_clk_cnt == BIT_LAST) begin
            r_clk_cnt <= '0;
            r_shift   <= (r_shift >> 1) | (r_rxs ? MSB_ONE : '0);
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == DATA_LAST) begin
              r_state <= S_STOP;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_clk_cnt == BIT_LAST) begin
            r_clk_cnt <= '0;
            if (r_rxs) begin
              // Leave at mid-stop so a back-to-back start edge is caught in time.
              r_state <= S_IDLE;
              if (!r_valid || rx_if.rx_ready) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_BREAK;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_BREAK: begin
          if (r_rxs) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rx_if.rx_data  = r_data;
  assign rx_if.rx_valid = r_valid;
  assign o_frame_err    = r_frame_err;
  assign o_overrun      = r_overrun;
  assign o_busy         = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb/tb_uart_rx_deframer.sv - scoreboard bench: frame-level model predicts bytes and flag pulses
module tb_uart_rx_deframer;
  localparam int C = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rxd = 1'b1;
  logic frame_err, overrun, busy;

  uart_rx_deframer_if #(.DATA_BITS(8)) rx_if ();

  uart_rx_deframer #(
    .CLK_FREQ (1_600_000),
    .BAUD     (100_000),
    .DATA_BITS(8)
  ) dut (
    .CLK100MHZ  (clk),
    .reset_n    (reset_n),
    .i_rxd      (rxd),
    .rx_if      (rx_if),
    .o_frame_err(frame_err),
    .o_overrun  (overrun),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_bytes[$];
  int         exp_flags[$];
  bit         held = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Flag codes: 2 = framing error, 1 = overrun.
  always @(negedge clk) begin
    if (reset_n) begin
      if (rx_if.rx_valid && rx_if.rx_ready) begin
        if (exp_bytes.size() == 0) check("unexpected_byte", int'(rx_if.rx_data), -1);
        else                       check("rx_data", int'(rx_if.rx_data), int'(exp_bytes.pop_front()));
      end
      if (frame_err || overrun) begin
        if (exp_flags.size() == 0) check("unexpected_flag", int'({frame_err, overrun}), 0);
        else                       check("flag", int'({frame_err, overrun}), exp_flags.pop_front());
      end
    end
  end

  // Every bit task is entered and left 2 ns after a rising edge.
  task automatic hold_bit(input logic b);
    rxd = b;
    repeat (C) @(posedge clk);
    #2;
  endtask

  task automatic idle_bits(input int n);
    repeat (n) hold_bit(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(d[i]);
    hold_bit(stop);
  endtask

  task automatic glitch(input int cycles);
    rxd = 1'b0;
    repeat (cycles) @(posedge clk);
    #2;
    rxd = 1'b1;
  endtask

  task automatic set_ready(input logic v);
    if (v && !rx_if.rx_ready) held = 1'b0;
    rx_if.rx_ready = v;
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic stop);
    if (!stop) begin
      exp_flags.push_back(2);
    end else if (held && !rx_if.rx_ready) begin
      exp_flags.push_back(1);
    end else begin
      exp_bytes.push_back(d);
      held = !rx_if.rx_ready;
    end
  endtask

  initial begin
    rx_if.rx_ready = 1'b1;
    @(posedge clk);
    #2;
    check("reset_valid", int'(rx_if.rx_valid), 0);
    check("reset_data", int'(rx_if.rx_data), 0);
    check("reset_frame_err", int'(frame_err), 0);
    check("reset_overrun", int'(overrun), 0);
    check("reset_busy", int'(busy), 0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    idle_bits(1);

    expect_frame(8'h55, 1'b1);
    fork
      send_frame(8'h55, 1'b1);
      begin
        int lat;
        bit seen;
        lat  = 0;
        seen = 1'b0;
        while (lat < 400 && !seen) begin
          @(posedge clk);
          #1;
          lat++;
          if (rx_if.rx_valid) seen = 1'b1;
        end
        check("latency", lat, 155);
        @(posedge clk);
        #1;
        check("valid_one_cycle", int'(rx_if.rx_valid), 0);
      end
    join
    idle_bits(1);

    glitch(4);
    check("busy_in_glitch", int'(busy), 1);
    repeat (12) @(posedge clk);
    #1;
    check("busy_after_glitch", int'(busy), 0);
    #1;
    idle_bits(1);

    expect_frame(8'hA5, 1'b0);
    send_frame(8'hA5, 1'b0);
    idle_bits(2);
    expect_frame(8'h3C, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle_bits(1);

    set_ready(1'b0);
    expect_frame(8'h11, 1'b1);
    send_frame(8'h11, 1'b1);
    expect_frame(8'h22, 1'b1);
    send_frame(8'h22, 1'b1);
    idle_bits(1);
    check("held_valid", int'(rx_if.rx_valid), 1);
    check("held_data", int'(rx_if.rx_data), 8'h11);
    set_ready(1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("drained_valid", int'(rx_if.rx_valid), 0);
    check("drained_data", int'(rx_if.rx_data), 8'h11);
    #1;

    expect_frame(8'hA5, 1'b1);
    expect_frame(8'h3C, 1'b1);
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle_bits(1);

    hold_bit(1'b0);
    for (int i = 0; i < 4; i++) hold_bit(1'b1);
    repeat (3) @(posedge clk);
    #4;
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", int'(rx_if.rx_valid), 0);
    check("async_rst_data", int'(rx_if.rx_data), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_frame_err", int'(frame_err), 0);
    check("async_rst_overrun", int'(overrun), 0);
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;
    idle_bits(1);
    expect_frame(8'h81, 1'b1);
    send_frame(8'h81, 1'b1);
    idle_bits(1);

    for (int k = 0; k < 40; k++) begin
      logic [7:0] d;
      logic       stop;
      d    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 9) == 0) begin
        glitch($urandom_range(1, 6));
        idle_bits(2);
      end
      if ($urandom_range(0, 3) == 0) set_ready(!rx_if.rx_ready);
      expect_frame(d, stop);
      send_frame(d, stop);
      if (!stop) idle_bits(2);
      else       idle_bits($urandom_range(0, 2));
    end

    set_ready(1'b1);
    idle_bits(2);
    check("bytes_outstanding", exp_bytes.size(), 0);
    check("flags_outstanding", exp_flags.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
